conv_win_sched: RTL and testbench

- Frame-level scheduler for the conv/FC datapath.
- Accepts one "frame loaded" handshake, then walks every KxK output window of the IMG_H x IMG_W frame in raster order, LANES windows per beat, emitting (row, col, first, last) tokens to the shared conv PE array.
- Limits in-flight beats with a credit counter refilled by datapath completions.
- Signals frame done once all beats have retired.

---
 rtl/conv_win_sched.sv | 197 +++++++++++++++++++
 tb/tb_conv_win_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_win_sched.sv
// conv_win_sched
//   Frame-level scheduler for the conv/FC datapath. After a frame-start
//   handshake it walks every KxK output window of an IMG_H x IMG_W frame in
//   raster order, LANES windows per beat, and emits (row, col, first, last)
//   tokens to the shared PE array. A credit counter limits the number of
//   beats in flight, and the datapath returns credits as beats complete. The
//   frame is reported done only after every beat has retired.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
//   high. Valid never depends on ready. While valid is high and ready is low,
//   the offered token is held stable.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_pre_valid/o_pre_ready    frame start request / scheduler idle
//   o_post_valid/i_post_ready  window beat to the datapath
//   o_row, o_col        output row, and output column of lane 0 (lane n = col+n)
//   o_first, o_last     beat is the first / last of the frame
//   i_ret_valid         one datapath beat completed (credit return)
//   o_busy              high in ISSUE or DRAIN
//   o_done              one-cycle pulse when the frame is fully retired
//   o_err               sticky: credit returned with nothing outstanding
//   o_state             current FSM state (debug)
//
// Optional build macro CONV_WIN_SCHED_PERF_EN adds these outputs:
//   o_stall_credit      ISSUE cycles with no credit
//   o_stall_bp          cycles where a beat is offered but not accepted
//   Both counters saturate, and both clear on reset and on frame start.

module conv_win_sched #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int LANES      = 2,
  parameter int MAX_OUTSTD = 4,
  localparam int OW = IMG_W - K + 1,
  localparam int OH = IMG_H - K + 1,
  localparam int RW = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pre_valid,
  output logic          o_pre_ready,
  output logic          o_post_valid,
  input  logic          i_post_ready,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_first,
  output logic          o_last,
  input  logic          i_ret_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [1:0]    o_state
`ifdef CONV_WIN_SCHED_PERF_EN
  ,
  output logic [31:0]   o_stall_credit,
  output logic [31:0]   o_stall_bp
`endif
);

  if (OW % LANES != 0) begin : g_bad_lanes
    $error("conv_win_sched: output width must be a multiple of LANES");
  end
  if (MAX_OUTSTD < 1 || MAX_OUTSTD > 15) begin : g_bad_outstd
    $error("conv_win_sched: MAX_OUTSTD must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]    CRED_MAX = 4'(MAX_OUTSTD);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - LANES);
  localparam logic [CW-1:0] COL_STEP = CW'(LANES);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    cred_q, cred_d;
  logic          err_q, err_d;

  logic in_issue;
  logic pre_fire;
  logic post_fire;

  assign in_issue  = (state_q == S_ISSUE);
  assign pre_fire  = i_pre_valid & o_pre_ready;
  assign post_fire = o_post_valid & i_post_ready;

  // All outputs are decoded from registered state. This means an
  // asynchronous reset drives them to idle values immediately.
  assign o_pre_ready  = (state_q == S_IDLE);
  assign o_post_valid = in_issue && (cred_q != 4'd0);
  assign o_row        = row_q;
  assign o_col        = col_q;
  assign o_first      = in_issue && (row_q == '0) && (col_q == '0);
  assign o_last       = in_issue && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign o_busy       = in_issue || (state_q == S_DRAIN);
  assign o_done       = (state_q == S_DONE);
  assign o_err        = err_q;
  assign o_state      = state_q;

  // Credit accounting. When an issue and a return happen in the same cycle,
  // they cancel out. A return with the counter already full is clamped and
  // flagged as an error.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    case ({post_fire, i_ret_valid})
      2'b10: cred_d = cred_q - 4'd1;
      2'b01: begin
        if (cred_q == CRED_MAX) err_d = 1'b1;
        else                    cred_d = cred_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Window walk and frame sequencing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (pre_fire) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_ISSUE: begin
        if (post_fire) begin
          if (o_last) begin
            state_d = S_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_ONE;
          end else begin
            col_d = col_q + COL_STEP;
          end
        end
      end
      // The check uses the post-update credit value. A return that arrives
      // in the DRAIN cycle itself therefore completes the drain, so DRAIN
      // takes a single cycle when returns keep pace with issue.
      S_DRAIN: begin
        if (cred_d == CRED_MAX) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

`ifdef CONV_WIN_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stall_credit <= '0;
      o_stall_bp     <= '0;
    end else if (pre_fire) begin
      o_stall_credit <= '0;
      o_stall_bp     <= '0;
    end else begin
      if (in_issue && (cred_q == 4'd0) && (o_stall_credit != 32'hFFFF_FFFF))
        o_stall_credit <= o_stall_credit + 32'd1;
      if (o_post_valid && !i_post_ready && (o_stall_bp != 32'hFFFF_FFFF))
        o_stall_bp <= o_stall_bp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// tb_conv_win_sched
//   Directed bench for conv_win_sched with default parameters (26x26 output
//   windows, 2 lanes, 4 credits). Inputs change and outputs are sampled 1ns
//   after each rising edge. Beats are scored against an expected token queue
//   that the bench builds from the raster-order window walk.

module tb_conv_win_sched;

  localparam int OW     = 26;
  localparam int OH     = 26;
  localparam int LANES  = 2;
  localparam int MAXO   = 4;
  localparam int NBEATS = (OW * OH) / LANES;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_pre_valid;
  logic       i_post_ready;
  logic       i_ret_valid;
  logic       o_pre_ready;
  logic       o_post_valid;
  logic [4:0] o_row;
  logic [4:0] o_col;
  logic       o_first;
  logic       o_last;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_state;
`ifdef CONV_WIN_SCHED_PERF_EN
  logic [31:0] o_stall_credit;
  logic [31:0] o_stall_bp;
`endif

  conv_win_sched dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_first      (o_first),
    .o_last       (o_last),
    .i_ret_valid  (i_ret_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_state      (o_state)
`ifdef CONV_WIN_SCHED_PERF_EN
    ,
    .o_stall_credit (o_stall_credit),
    .o_stall_bp     (o_stall_bp)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {o_pre_ready, o_post_valid, o_first, o_last, o_busy, o_done, o_err,
                 o_state, o_row, o_col},
          {1'b1, 6'b0, 2'b0, 10'b0});
  endtask

  // Assert reset between clock edges and check the outputs before any edge.
  task automatic async_reset(input string name);
    #2 i_rst = 1'b0;
    #1 check_reset_outs(name);
    i_pre_valid  = 1'b0;
    i_post_ready = 1'b0;
    i_ret_valid  = 1'b0;
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    tick;
  endtask

  task automatic fill_queue;
    logic [4:0] r5, c5;
    logic f, l;
    exp_q.delete();
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c += LANES) begin
        r5 = 5'(r);
        c5 = 5'(c);
        f  = (r == 0) && (c == 0);
        l  = (r == OH - 1) && (c == OW - LANES);
        exp_q.push_back({r5, c5, f, l});
      end
    end
  endtask

  // ---------------- driver: one complete frame ----------------
  // bp:       random 50% backpressure on i_post_ready
  // hold_pre: leave i_pre_valid high for the whole frame
  // probe:    withhold returns until issue stops on the credit limit
  task automatic run_frame(input bit bp, input bit hold_pre, input bit probe,
                           output int beats, output int lat, output int stalls);
    int          cyc = 0;
    int          owed = 0;
    int          pre_hi = 0;
    bit          fin = 0;
    bit          stalled = 0;
    bit          probe_done = 0;
    logic        fire;
    logic [11:0] tok, prev_tok, e;
    beats = 0; lat = 0; stalls = 0;
    prev_tok = '0;
    fill_queue();
    i_pre_valid  = 1'b1;
    i_post_ready = 1'b0;
    i_ret_valid  = 1'b0;
    check("pre_ready_idle", o_pre_ready, 1);
    tick;
    if (!hold_pre) i_pre_valid = 1'b0;
    while (!fin && cyc < 6000) begin
      cyc++;
      tok = {o_row, o_col, o_first, o_last};
      if (stalled) check("token_hold", tok, prev_tok);
      if (o_pre_ready) pre_hi++;
      if (o_done) begin
        fin = 1;
        lat = cyc;
      end
      if (probe && !probe_done && o_state == 2'd1 && !o_post_valid) begin
        check("credit_limit_beats", beats, MAXO);
        probe_done = 1;
      end
      i_post_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      fire = o_post_valid & i_post_ready;
      if ((!probe || probe_done) && owed > 0) begin
        i_ret_valid = 1'b1;
        owed--;
      end else begin
        i_ret_valid = 1'b0;
      end
      if (fire) owed++;
      stalled = o_post_valid & ~i_post_ready;
      if (stalled) stalls++;
      if (fire) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("extra_beat", beats, NBEATS);
        end else begin
          e = exp_q.pop_front();
          check("beat_token", tok, e);
        end
        if (beats == 1)      check("beat1",   tok, {5'd0,  5'd0,  1'b1, 1'b0});
        if (beats == 13)     check("beat13",  tok, {5'd0,  5'd24, 1'b0, 1'b0});
        if (beats == 14)     check("beat14",  tok, {5'd1,  5'd0,  1'b0, 1'b0});
        if (beats == NBEATS) check("beat338", tok, {5'd25, 5'd24, 1'b0, 1'b1});
      end
      prev_tok = tok;
      tick;
    end
    i_ret_valid  = 1'b0;
    i_post_ready = 1'b0;
    if (!fin) check("done_timeout", 0, 1);
    check("beat_count", beats, NBEATS);
    check("queue_empty", exp_q.size(), 0);
    check("done_single_cycle", o_done, 0);
    check("pre_not_accepted_busy", pre_hi, 0);
    if (hold_pre) check("pre_ready_after_done", {o_pre_ready, o_state}, {1'b1, 2'd0});
  endtask

  // Issue n beats with returns one cycle after each fire, then stop
  // mid-frame, at the sample point just after the n-th beat.
  task automatic issue_n(input int n);
    int cyc = 0;
    int fired = 0;
    bit owed = 0;
    i_pre_valid = 1'b1;
    tick;
    i_pre_valid = 1'b0;
    while (fired < n && cyc < 2000) begin
      cyc++;
      i_post_ready = 1'b1;
      i_ret_valid  = owed;
      owed = o_post_valid;
      if (o_post_valid) fired++;
      tick;
    end
    i_ret_valid = 1'b0;
    if (fired < n) check("issue_timeout", fired, n);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       pre_valid;
    logic       post_ready;
    logic       ret_valid;
    logic       exp_pre_ready;
    logic       exp_post_valid;
    logic       exp_first;
    logic       exp_busy;
    logic [4:0] exp_col;
  } vec_t;

  vec_t vecs[12];
  int   beats, lat, stalls;

  initial begin
    // Credit-limit walk: outputs are checked, then the inputs are applied
    // for the next edge.
    vecs[0]  = '{1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd4};
    vecs[4]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd6};
    vecs[5]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8};
    vecs[6]  = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8};
    vecs[7]  = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd8};
    vecs[8]  = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 5'd10};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd10};
    vecs[10] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd10};
    vecs[11] = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd12};

    i_rst        = 1'b0;
    i_pre_valid  = 1'b0;
    i_post_ready = 1'b0;
    i_ret_valid  = 1'b0;
    #12;
    check_reset_outs("reset_outputs");
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    tick;

    // Credit limit and single-return release, table driven.
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_pre_ready", i),  o_pre_ready,  vecs[i].exp_pre_ready);
      check($sformatf("vec%0d_post_valid", i), o_post_valid, vecs[i].exp_post_valid);
      check($sformatf("vec%0d_first", i),      o_first,      vecs[i].exp_first);
      check($sformatf("vec%0d_busy", i),       o_busy,       vecs[i].exp_busy);
      check($sformatf("vec%0d_col", i),        o_col,        vecs[i].exp_col);
      i_pre_valid  = vecs[i].pre_valid;
      i_post_ready = vecs[i].post_ready;
      i_ret_valid  = vecs[i].ret_valid;
      tick;
    end
    i_post_ready = 1'b0;
    i_ret_valid  = 1'b0;
    async_reset("abort_after_table");

    // Single frame with returns one cycle after each fire.
    run_frame(1'b0, 1'b0, 1'b0, beats, lat, stalls);
    check("frame_latency", lat, NBEATS + 2);
    check("err_after_frame", o_err, 0);

    // 50% backpressure.
    run_frame(1'b1, 1'b0, 1'b0, beats, lat, stalls);
    check("bp_stalls_seen", (stalls > 0), 1);
`ifdef CONV_WIN_SCHED_PERF_EN
    check("perf_stall_bp", o_stall_bp, stalls);
`endif

    // Back-to-back frames with i_pre_valid held high.
    run_frame(1'b0, 1'b1, 1'b0, beats, lat, stalls);
    run_frame(1'b0, 1'b1, 1'b0, beats, lat, stalls);
    i_pre_valid = 1'b0;
    tick;

    // Reset in the middle of a frame, then restart.
    issue_n(100);
    check("mid_frame_busy", o_busy, 1);
    async_reset("abort_at_beat100");
    run_frame(1'b0, 1'b0, 1'b0, beats, lat, stalls);
    check("err_after_restart", o_err, 0);

    // Credit return while idle and full.
    i_ret_valid = 1'b1;
    tick;
    i_ret_valid = 1'b0;
    check("err_set", o_err, 1);
    tick;
    tick;
    check("err_sticky", o_err, 1);
    run_frame(1'b0, 1'b0, 1'b1, beats, lat, stalls);
    check("err_sticky_after_frame", o_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
